pipelined_add_sub: RTL and testbench

//  Parametrised WIDTH-bit adder/subtractor split into STAGES carry-pipelined chunks.

---
 rtl/pipelined_add_sub_pkg.sv | 26 ++
 rtl/pipelined_add_sub_if.sv | 33 +++
 rtl/pipelined_add_sub_chunk_adder.sv | 37 +++
 rtl/pipelined_add_sub.sv | 138 +++++++++++++
 tb/tb_pipelined_add_sub.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_add_sub_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_add_sub_pkg
// Shared definitions for the carry-pipelined adder/subtractor:
//   op_e          operation select carried on the 'sub' line (add / subtract)
//   params_legal  WIDTH/STAGES legality rule, evaluated at elaboration
//   full_add      one-bit full-adder cell, returns {carry_out, sum}
// -----------------------------------------------------------------------------
package pipelined_add_sub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // The chunk width must be a whole number of bits, and at least one stage
    // must exist, so STAGES has to divide WIDTH exactly.
    function automatic bit params_legal(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) &&
               ((width % stages) == 0);
    endfunction

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// -----------------------------------------------------------------------------
// pipelined_add_sub_if
// Handshake and data bundle of the pipelined adder/subtractor.
//   in_valid/in_ready    operation handshake (a, b, sub sampled on accept)
//   out_valid/out_ready  result handshake (sum, cout, overflow, zero)
// Modports: master = client issuing operations, slave = the adder.
// -----------------------------------------------------------------------------
interface pipelined_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero
    );

endinterface

// File: rtl/pipelined_add_sub_chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
// Combinational N-bit ripple chain built from one-bit full-adder cells.
//   a, b      N-bit operand slices
//   ci        carry into bit 0
//   s         N-bit sum slice
//   co        carry out of bit N-1
//   c_msb_in  carry into bit N-1 (used for signed overflow on the top slice)
// -----------------------------------------------------------------------------
module chunk_adder
    import pipelined_add_sub_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [N:0] carry;

    // Ripple the carry from bit 0 upwards, one full-adder cell per bit.
    always_comb begin
        s        = '0;
        carry    = '0;
        carry[0] = ci;
        for (int i = 0; i < N; i++) begin
            {carry[i+1], s[i]} = full_add(a[i], b[i], carry[i]);
        end
        co       = carry[N];
        c_msb_in = carry[N-1];
    end

endmodule

// File: rtl/pipelined_add_sub.sv
// -----------------------------------------------------------------------------
// pipelined_add_sub
// WIDTH-bit adder/subtractor split into STAGES carry-pipelined chunks of
// WIDTH/STAGES bits. One operation per cycle, latency STAGES cycles.
//   clk    rising-edge clock
//   reset  synchronous, active-high; flushes every in-flight operation
//   bus    pipelined_add_sub_if slave: in_valid/in_ready/a/b/sub in,
//          out_valid/out_ready/sum/cout/overflow/zero out
// -----------------------------------------------------------------------------
module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic              clk,
    input logic              reset,
    pipelined_add_sub_if.slave bus
);

    localparam int CHUNK = (STAGES >= 1) ? (WIDTH / STAGES) : 1;

    if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
        $fatal(1, "pipelined_add_sub: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
    end

    logic             en;
    logic             out_valid_int;
    logic [WIDTH-1:0] b_eff;

    // The whole pipeline moves in lock step; it only freezes when the output
    // register holds a result nobody has taken yet.
    assign en            = !out_valid_int || bus.out_ready;
    assign bus.in_ready  = en && !reset;
    assign bus.out_valid = out_valid_int;

    // Subtraction is a + ~b + 1: b is inverted on entry and the +1 enters as
    // the carry into stage 0, so 'sub' needs no further pipelining.
    assign b_eff = (op_e'(bus.sub) == OP_SUB) ? ~bus.b : bus.b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO   = k * CHUNK;
        localparam int PEND = WIDTH - LO;

        // word holds finished sum slices below LO and still-unused a slices above.
        logic [WIDTH-1:0] word_in;
        logic [WIDTH-1:0] word_next;
        logic [WIDTH-1:0] word_q;
        logic [PEND-1:0]  b_in;
        logic             carry_in;
        logic             valid_in;
        logic [CHUNK-1:0] s;
        logic             co;
        logic             c_msb;
        logic             carry_q;
        logic             valid_q;

        if (k == 0) begin : g_first
            assign word_in  = bus.a;
            assign b_in     = b_eff;
            assign carry_in = bus.sub;
            assign valid_in = bus.in_valid && bus.in_ready;
        end else begin : g_next
            assign word_in  = g_stage[k-1].word_q;
            assign b_in     = g_stage[k-1].g_pend.b_q;
            assign carry_in = g_stage[k-1].carry_q;
            assign valid_in = g_stage[k-1].valid_q;
        end

        chunk_adder #(.N(CHUNK)) u_chunk (
            .a        (word_in[LO +: CHUNK]),
            .b        (b_in[CHUNK-1:0]),
            .ci       (carry_in),
            .s        (s),
            .co       (co),
            .c_msb_in (c_msb)
        );

        // Drop this stage's sum slice into place over the consumed a slice.
        always_comb begin
            word_next              = word_in;
            word_next[LO +: CHUNK] = s;
        end

        // Stage register: data, carry and valid advance together; a cleared
        // valid bit travels down the pipe as a bubble.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                word_q  <= '0;
            end else if (en) begin
                valid_q <= valid_in;
                carry_q <= co;
                word_q  <= word_next;
            end
        end

        if (k < STAGES - 1) begin : g_pend
            logic [PEND-CHUNK-1:0] b_q;
            logic                  c_msb_unused;

            // Only the top slice needs its carry-into-MSB.
            assign c_msb_unused = c_msb;

            // Skew the still-unused b slices so each meets its carry one stage later.
            always_ff @(posedge clk) begin
                if (reset) begin
                    b_q <= '0;
                end else if (en) begin
                    b_q <= b_in[PEND-1:CHUNK];
                end
            end
        end else begin : g_last
            logic overflow_q;
            logic zero_q;

            // Flags are registered alongside the final sum so they always
            // describe the same result that sits in word_q.
            always_ff @(posedge clk) begin
                if (reset) begin
                    overflow_q <= 1'b0;
                    zero_q     <= 1'b0;
                end else if (en) begin
                    overflow_q <= c_msb ^ co;
                    zero_q     <= (word_next == '0);
                end
            end

            assign bus.sum      = word_q;
            assign bus.cout     = carry_q;
            assign bus.overflow = overflow_q;
            assign bus.zero     = zero_q;
            assign out_valid_int = valid_q;
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_add_sub
// Directed bench for pipelined_add_sub at WIDTH=8 with STAGES=4 (dut) and
// STAGES=1 (dut1). Hand-computed vectors for latency, flags, back-to-back
// add/sub, backpressure and mid-flight reset, plus a scoreboard that follows
// every accepted operation to its result.
// -----------------------------------------------------------------------------
module tb_pipelined_add_sub;

    localparam int WIDTH = 8;
    localparam int RAND_OPS = 400;

    typedef logic [10:0] result_t;  // {sum, cout, overflow, zero}

    // Backpressure vectors and their hand-computed results.
    localparam logic [7:0] T4_A   [6] = '{8'h10, 8'h30, 8'h40, 8'h01, 8'hC0, 8'h00};
    localparam logic [7:0] T4_B   [6] = '{8'h20, 8'h05, 8'h40, 8'h02, 8'hC0, 8'h00};
    localparam logic       T4_SUB [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    localparam result_t    T4_EXP [6] = '{{8'h30, 3'b000}, {8'h2B, 3'b100},
                                          {8'h80, 3'b010}, {8'hFF, 3'b000},
                                          {8'h80, 3'b100}, {8'h00, 3'b101}};

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipelined_add_sub_if #(.WIDTH(WIDTH)) bus ();
    pipelined_add_sub_if #(.WIDTH(WIDTH)) bus1 ();

    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int      check_count = 0;
    int      error_count = 0;
    result_t exp_q[$];
    result_t exp_q1[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference: {cout,sum} = a + (sub ? ~b : b) + sub, overflow from operand signs.
    function automatic result_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        logic [8:0] full;
        logic [7:0] bb;
        logic       ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
        if (sub) ovf = (a[7] != b[7]) && (full[7] != a[7]);
        else     ovf = (a[7] == b[7]) && (full[7] != a[7]);
        return {full[7:0], full[8], ovf, full[7:0] == 8'd0};
    endfunction

    function automatic result_t dutOut();
        return {bus.sum, bus.cout, bus.overflow, bus.zero};
    endfunction

    function automatic result_t dut1Out();
        return {bus1.sum, bus1.cout, bus1.overflow, bus1.zero};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic sub);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = sub;
        tick();
    endtask

    // Scoreboard: values are stable from the previous posedge+1 until the next
    // posedge, so the negedge sees exactly what the next edge will transfer.
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            exp_q.delete();
            exp_q1.delete();
        end else begin
            if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.sub));
            if (bus.out_valid && bus.out_ready) begin
                checkOutput("dut result has pending op", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) checkOutput("dut scoreboard", dutOut(), exp_q.pop_front());
            end
            if (bus1.in_valid && bus1.in_ready) exp_q1.push_back(model(bus1.a, bus1.b, bus1.sub));
            if (bus1.out_valid && bus1.out_ready) begin
                checkOutput("dut1 result has pending op", 32'(exp_q1.size() != 0), 1);
                if (exp_q1.size() != 0) checkOutput("dut1 scoreboard", dut1Out(), exp_q1.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  accepted;
        int  accepted1;
        int  pop_idx;
        bit  was_acc;
        bit  was_acc1;
        bit  seen_valid;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        bus1.in_valid = 1'b0;
        bus1.a        = '0;
        bus1.b        = '0;
        bus1.sub      = 1'b0;
        bus1.out_ready = 1'b1;
        tick();
        tick();
        checkOutput("in_ready during reset", 32'(bus.in_ready), 0);
        checkOutput("outputs after reset", 32'({bus.out_valid, dutOut()}), 0);
        reset = 1'b0;

        // Add with carry out and zero, then a borrowing subtract right behind it.
        applyStimulus(8'hFF, 8'h01, 1'b0);
        applyStimulus(8'h05, 8'h07, 1'b1);
        bus.in_valid = 1'b0;
        tick();
        checkOutput("t1 not before 4 cycles", 32'(bus.out_valid), 0);
        tick();
        checkOutput("t1 result", 32'({bus.out_valid, dutOut()}), 32'({1'b1, 8'h00, 3'b101}));
        tick();
        checkOutput("t3 borrow result", 32'({bus.out_valid, dutOut()}), 32'({1'b1, 8'hFE, 3'b000}));
        tick();
        checkOutput("t3 drained", 32'(bus.out_valid), 0);

        // Signed overflow in both directions.
        applyStimulus(8'h7F, 8'h01, 1'b0);
        applyStimulus(8'h80, 8'h01, 1'b1);
        bus.in_valid = 1'b0;
        tick();
        tick();
        checkOutput("t2 add overflow", 32'({bus.out_valid, dutOut()}), 32'({1'b1, 8'h80, 3'b010}));
        tick();
        checkOutput("t2 sub overflow", 32'({bus.out_valid, dutOut()}), 32'({1'b1, 8'h7F, 3'b110}));
        tick();

        // Backpressure: only four operations fit while the output is blocked.
        bus.out_ready = 1'b0;
        accepted = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            bus.in_valid = 1'b1;
            bus.a        = T4_A[accepted];
            bus.b        = T4_B[accepted];
            bus.sub      = T4_SUB[accepted];
            #1;
            was_acc = bus.in_ready;
            tick();
            if (was_acc) accepted++;
        end
        checkOutput("t4 accepted while blocked", 32'(accepted), 4);
        checkOutput("t4 in_ready low when full", 32'(bus.in_ready), 0);
        checkOutput("t4 head held", 32'({bus.out_valid, dutOut()}), 32'({1'b1, T4_EXP[0]}));
        tick();
        checkOutput("t4 head stable", 32'({bus.out_valid, dutOut()}), 32'({1'b1, T4_EXP[0]}));

        bus.out_ready = 1'b1;
        pop_idx = 0;
        for (int cyc = 0; cyc < 30 && pop_idx < 6; cyc++) begin
            if (accepted < 6) begin
                bus.in_valid = 1'b1;
                bus.a        = T4_A[accepted];
                bus.b        = T4_B[accepted];
                bus.sub      = T4_SUB[accepted];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            was_acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                checkOutput($sformatf("t4 order %0d", pop_idx), 32'(dutOut()), 32'(T4_EXP[pop_idx]));
                pop_idx++;
            end
            tick();
            if (was_acc) accepted++;
        end
        bus.in_valid = 1'b0;
        checkOutput("t4 results delivered", 32'(pop_idx), 6);
        checkOutput("t4 nothing left over", 32'(exp_q.size()), 0);
        tick();

        // Reset with three operations in flight: none of them may surface.
        applyStimulus(8'h11, 8'h22, 1'b0);
        applyStimulus(8'h33, 8'h01, 1'b1);
        applyStimulus(8'hFE, 8'hFF, 1'b0);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("t5 in_ready during reset", 32'(bus.in_ready), 0);
        tick();
        reset = 1'b0;
        checkOutput("t5 flushed outputs", 32'({bus.out_valid, dutOut()}), 0);
        seen_valid = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (bus.out_valid) seen_valid = 1'b1;
            tick();
        end
        checkOutput("t5 no result after reset", 32'(seen_valid), 0);
        applyStimulus(8'h80, 8'h80, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        checkOutput("t5 not before 4 cycles", 32'(bus.out_valid), 0);
        tick();
        checkOutput("t5 post-reset op", 32'({bus.out_valid, dutOut()}), 32'({1'b1, 8'h00, 3'b111}));
        tick();

        // Single-stage build: a plain registered adder.
        bus1.in_valid = 1'b1;
        bus1.a        = 8'h7F;
        bus1.b        = 8'h01;
        bus1.sub      = 1'b0;
        tick();
        bus1.in_valid = 1'b0;
        checkOutput("s1 latency one", 32'({bus1.out_valid, dut1Out()}), 32'({1'b1, 8'h80, 3'b010}));
        tick();
        checkOutput("s1 drained", 32'(bus1.out_valid), 0);

        // Random valid/ready on both builds, followed by the scoreboard.
        accepted  = 0;
        accepted1 = 0;
        for (int cyc = 0; cyc < 4000 && (accepted < RAND_OPS || accepted1 < RAND_OPS); cyc++) begin
            bus.in_valid   = (accepted < RAND_OPS) && ($urandom_range(3) != 0);
            bus.a          = 8'($urandom);
            bus.b          = 8'($urandom);
            bus.sub        = 1'($urandom);
            bus.out_ready  = ($urandom_range(3) != 0);
            bus1.in_valid  = (accepted1 < RAND_OPS) && ($urandom_range(3) != 0);
            bus1.a         = 8'($urandom);
            bus1.b         = 8'($urandom);
            bus1.sub       = 1'($urandom);
            bus1.out_ready = ($urandom_range(3) != 0);
            #1;
            was_acc  = bus.in_valid && bus.in_ready;
            was_acc1 = bus1.in_valid && bus1.in_ready;
            tick();
            if (was_acc)  accepted++;
            if (was_acc1) accepted1++;
        end
        bus.in_valid   = 1'b0;
        bus1.in_valid  = 1'b0;
        bus.out_ready  = 1'b1;
        bus1.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && (exp_q.size() + exp_q1.size()) != 0; cyc++) tick();
        tick();
        checkOutput("sweep ops accepted dut", 32'(accepted), RAND_OPS);
        checkOutput("sweep ops accepted dut1", 32'(accepted1), RAND_OPS);
        checkOutput("sweep drained", 32'(exp_q.size() + exp_q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
